// File: rtl/tc_scan_scheduler.sv
// Scheduler for the shared AD7124 thermocouple SPI bus.
// Sequences per-device configuration, then periodic full-sweep reads.
module tc_scan_scheduler #(
  parameter int unsigned SCAN_PERIOD = 100000,
  parameter int unsigned CFG_TIMEOUT = 1000000,
  parameter int unsigned RD_TIMEOUT  = 500000,
  parameter int unsigned GAP_CYCLES  = 16
) (
  input  logic        PL_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cfg_req,
  input  logic [3:0]  cfg_select_in,
  input  logic [7:0]  cfg_mask,
  input  logic        err_clr,
  input  logic [7:0]  F_configure_stop,
  input  logic        rd_done,
  output logic [3:0]  configure_select,
  output logic [7:0]  start_configure,
  output logic        start_rd,
  output logic        cfg_valid,
  output logic        cfg_done,
  output logic        busy,
  output logic [2:0]  state_o,
  output logic        err_cfg_to,
  output logic [2:0]  err_dev,
  output logic        err_rd_to,
  output logic [15:0] scan_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CFG_ISSUE = 3'd1,
    CFG_WAIT  = 3'd2,
    CFG_GAP   = 3'd3,
    RD_RUN    = 3'd4,
    RD_WAIT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] per_q, per_d;
  logic [7:0]  mask_q, mask_d;
  logic [3:0]  sel_q, sel_d;
  logic [2:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic        tmo_q, tmo_d;
  logic [3:0]  cfg_sel_q, cfg_sel_d;
  logic [7:0]  start_cfg_q, start_cfg_d;
  logic        start_rd_q, start_rd_d;
  logic        cfg_valid_q, cfg_valid_d;
  logic        cfg_done_q, cfg_done_d;
  logic        busy_q, busy_d;
  logic        err_cfg_q, err_cfg_d;
  logic [2:0]  err_dev_q, err_dev_d;
  logic        err_rd_q, err_rd_d;
  logic [15:0] scan_q, scan_d;
  logic        seq_start;
  logic [3:0]  first_dev, next_dev;

  // {found, index} of the lowest set bit
  function automatic logic [3:0] low_bit(input logic [7:0] m);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign first_dev = low_bit(cfg_mask);
  assign next_dev  = low_bit(mask_q & ~((8'd2 << idx_q) - 8'd1));

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    cfg_sel_d   = cfg_sel_q;
    start_cfg_d = start_cfg_q;
    cfg_valid_d = cfg_valid_q;
    cfg_done_d  = 1'b0;
    err_dev_d   = err_dev_q;
    scan_d      = scan_q;
    pend_d      = pend_q | cfg_req;
    err_cfg_d   = err_cfg_q & ~err_clr;
    err_rd_d    = err_rd_q & ~err_clr;
    seq_start   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          if (pend_q || !cfg_valid_q) seq_start = 1'b1;
          else state_d = RD_RUN;
        end
      end
      CFG_ISSUE: begin
        start_cfg_d = 8'd1 << idx_q;
        cfg_sel_d   = sel_q;
        state_d     = CFG_WAIT;
      end
      CFG_WAIT: begin
        if (F_configure_stop[idx_q]) begin
          start_cfg_d = 8'd0;
          state_d     = CFG_GAP;
        end else if (cnt_q >= CFG_TIMEOUT - 1) begin
          err_cfg_d   = 1'b1;
          err_dev_d   = idx_q;
          tmo_d       = 1'b1;
          start_cfg_d = 8'd0;
          state_d     = CFG_GAP;
        end
      end
      CFG_GAP: begin
        if (cnt_q >= GAP_CYCLES - 1) begin
          if (next_dev[3] && enable) begin
            idx_d   = next_dev[2:0];
            state_d = CFG_ISSUE;
          end else if (next_dev[3]) begin
            state_d = IDLE;
          end else begin
            if (!tmo_q) begin
              cfg_valid_d = 1'b1;
              cfg_done_d  = 1'b1;
            end
            state_d = enable ? RD_RUN : IDLE;
          end
        end
      end
      RD_RUN: begin
        if (rd_done) begin
          scan_d  = scan_q + 16'd1;
          state_d = RD_WAIT;
        end else if (cnt_q >= RD_TIMEOUT - 1) begin
          err_rd_d = 1'b1;
          state_d  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q >= GAP_CYCLES - 1 && per_q >= SCAN_PERIOD - 1) begin
          if (enable && (pend_q || !cfg_valid_q)) seq_start = 1'b1;
          else if (enable) state_d = RD_RUN;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // a cfg_req in the start cycle keeps pending set
    if (seq_start) begin
      mask_d      = cfg_mask;
      sel_d       = cfg_select_in;
      pend_d      = cfg_req;
      tmo_d       = 1'b0;
      cfg_valid_d = 1'b0;
      if (first_dev[3]) begin
        idx_d   = first_dev[2:0];
        state_d = CFG_ISSUE;
      end else begin
        cfg_valid_d = 1'b1;
        cfg_done_d  = 1'b1;
        state_d     = RD_RUN;
      end
    end

    cnt_d = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
    if (state_d == RD_RUN && state_q != RD_RUN) per_d = 32'd0;
    else per_d = (&per_q) ? per_q : per_q + 32'd1;
    start_rd_d = (state_d == RD_RUN);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge PL_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      per_q       <= '0;
      mask_q      <= '0;
      sel_q       <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      tmo_q       <= 1'b0;
      cfg_sel_q   <= '0;
      start_cfg_q <= '0;
      start_rd_q  <= 1'b0;
      cfg_valid_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_cfg_q   <= 1'b0;
      err_dev_q   <= '0;
      err_rd_q    <= 1'b0;
      scan_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
      mask_q      <= mask_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      tmo_q       <= tmo_d;
      cfg_sel_q   <= cfg_sel_d;
      start_cfg_q <= start_cfg_d;
      start_rd_q  <= start_rd_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_done_q  <= cfg_done_d;
      busy_q      <= busy_d;
      err_cfg_q   <= err_cfg_d;
      err_dev_q   <= err_dev_d;
      err_rd_q    <= err_rd_d;
      scan_q      <= scan_d;
    end
  end

  assign configure_select = cfg_sel_q;
  assign start_configure  = start_cfg_q;
  assign start_rd         = start_rd_q;
  assign cfg_valid        = cfg_valid_q;
  assign cfg_done         = cfg_done_q;
  assign busy             = busy_q;
  assign state_o          = state_q;
  assign err_cfg_to       = err_cfg_q;
  assign err_dev          = err_dev_q;
  assign err_rd_to        = err_rd_q;
  assign scan_count       = scan_q;

endmodule

// File: tb/tb_tc_scan_scheduler.sv
// Bench for tc_scan_scheduler: engine emulators, event scoreboard,
// and a transaction-level model of the configure/read schedule.
module tb_tc_scan_scheduler;
  localparam int P   = 200;
  localparam int CT  = 100;
  localparam int RT  = 150;
  localparam int GAP = 4;

  logic        PL_clk = 0;
  logic        rst = 1;
  logic        enable = 0;
  logic        cfg_req = 0;
  logic [3:0]  cfg_select_in = 0;
  logic [7:0]  cfg_mask = 0;
  logic        err_clr = 0;
  logic [7:0]  F_configure_stop = 0;
  logic        rd_done = 0;
  logic [3:0]  configure_select;
  logic [7:0]  start_configure;
  logic        start_rd, cfg_valid, cfg_done, busy;
  logic [2:0]  state_o, err_dev;
  logic        err_cfg_to, err_rd_to;
  logic [15:0] scan_count;

  tc_scan_scheduler #(
    .SCAN_PERIOD(P), .CFG_TIMEOUT(CT),
    .RD_TIMEOUT(RT), .GAP_CYCLES(GAP)
  ) dut (
    .PL_clk(PL_clk), .rst(rst), .enable(enable),
    .cfg_req(cfg_req), .cfg_select_in(cfg_select_in),
    .cfg_mask(cfg_mask), .err_clr(err_clr),
    .F_configure_stop(F_configure_stop), .rd_done(rd_done),
    .configure_select(configure_select),
    .start_configure(start_configure), .start_rd(start_rd),
    .cfg_valid(cfg_valid), .cfg_done(cfg_done), .busy(busy),
    .state_o(state_o), .err_cfg_to(err_cfg_to),
    .err_dev(err_dev), .err_rd_to(err_rd_to),
    .scan_count(scan_count)
  );

  always #5 PL_clk = ~PL_clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // kind: 1 = configure start, 2 = cfg_done, 3 = read start
  typedef struct {
    int kind;
    int dev;
    int sel;
    int cnt;
    bit chk_dt;
  } ev_t;

  ev_t sb[$];
  int  m_count = 0;
  int  stop_dly[8];
  bit  rd_hang = 0;
  int  cyc = 0;
  int  last_rd = 0;
  int  viol = 0;

  task automatic push_cfg_seq(input logic [7:0] m, input int s,
                              input bit done);
    for (int i = 0; i < 8; i++)
      if (m[i]) sb.push_back('{1, i, s, 0, 1'b0});
    if (done) sb.push_back('{2, 0, 0, 0, 1'b0});
  endtask

  task automatic push_rd(input bit chk, input bit hang);
    sb.push_back('{3, 0, 0, m_count, chk});
    if (!hang) m_count = (m_count + 1) & 16'hFFFF;
  endtask

  task automatic observe(input ev_t o);
    ev_t e;
    if (sb.size() == 0) begin
      check("unexpected_event", o.kind, 0);
      return;
    end
    e = sb.pop_front();
    check("event_kind", o.kind, e.kind);
    if (e.kind == 1 && o.kind == 1) begin
      check("cfg_dev", o.dev, e.dev);
      check("cfg_sel", o.sel, e.sel);
    end
    if (e.kind == 3 && o.kind == 3) begin
      check("scan_count_at_rd", o.cnt, e.cnt);
      if (e.chk_dt) check("rd_period", cyc - last_rd, P);
    end
  endtask

  // monitor
  initial begin
    logic [7:0] prev_sc;
    logic       prev_rd;
    int         d;
    prev_sc = 0;
    prev_rd = 0;
    forever begin
      @(negedge PL_clk);
      cyc++;
      if ((start_rd && |start_configure) || !$onehot0(start_configure))
        viol++;
      if (rst) begin
        if (cfg_done) observe('{2, 0, 0, 0, 1'b0});
        if (start_configure != 0 && prev_sc == 0) begin
          d = 0;
          for (int i = 0; i < 8; i++) if (start_configure[i]) d = i;
          observe('{1, d, int'(configure_select), 0, 1'b0});
        end
        if (start_rd && !prev_rd) begin
          observe('{3, 0, 0, int'(scan_count), 1'b0});
          last_rd = cyc;
        end
      end
      prev_sc = start_configure;
      prev_rd = start_rd;
    end
  end

  // configure engine emulator, with stray stop bits for other devices
  initial begin
    int d, dly, n;
    bit act;
    act = 0; d = 0; dly = 0; n = 0;
    forever begin
      @(negedge PL_clk);
      F_configure_stop = '0;
      if (start_configure == 0) act = 0;
      else if (!act) begin
        act = 1;
        n = 0;
        for (int i = 0; i < 8; i++) if (start_configure[i]) d = i;
        dly = stop_dly[d];
      end else begin
        n++;
        if (n == 1 && dly > 3) F_configure_stop[(d + 1) % 8] = 1'b1;
        if (dly != 0 && n == dly) F_configure_stop[d] = 1'b1;
      end
    end
  end

  // read engine emulator, with stray rd_done while configuring
  initial begin
    int n, dly;
    bit act, hang;
    act = 0; hang = 0; n = 0; dly = 0;
    forever begin
      @(negedge PL_clk);
      rd_done = 0;
      if (act && !start_rd) act = 0;
      if (start_rd && !act) begin
        act = 1;
        n = 0;
        hang = rd_hang;
        dly = $urandom_range(100, 1);
      end else if (act) begin
        n++;
        if (!hang && n == dly) rd_done = 1;
      end else if (start_configure != 0 && $urandom_range(15, 0) == 0) begin
        rd_done = 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge PL_clk);
    #1;
  endtask

  task automatic wait_drain(input string nm);
    int b;
    b = 0;
    while (sb.size() != 0 && b < 3000) begin
      tick(1);
      b++;
    end
    if (sb.size() != 0) begin
      check({"drain_", nm}, sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic pulse_req();
    cfg_req = 1; tick(1); cfg_req = 0;
  endtask

  task automatic pulse_clr();
    err_clr = 1; tick(1); err_clr = 0;
  endtask

  initial begin
    logic [7:0] m;
    logic [3:0] s;
    int hang;
    for (int i = 0; i < 8; i++) stop_dly[i] = 10;
    #2 rst = 0;
    tick(3);
    check("rst_state", int'(state_o), 0);
    check("rst_outs", int'({start_configure, start_rd, cfg_valid,
                            cfg_done, busy, configure_select}), 0);
    check("rst_err", int'({err_cfg_to, err_dev, err_rd_to}), 0);
    check("rst_scan", int'(scan_count), 0);
    rst = 1;
    tick(5);
    check("idle_no_enable", int'(busy), 0);

    // two-device configure, then first read
    cfg_mask = 8'h05;
    cfg_select_in = 4'h3;
    push_cfg_seq(8'h05, 3, 1);
    push_rd(0, 0);
    enable = 1;
    wait_drain("first_cfg");
    check("cfg_valid_1", int'(cfg_valid), 1);
    check("cfg_sel_held", int'(configure_select), 3);

    for (int k = 0; k < 3; k++) begin
      push_rd(1, 0);
      wait_drain("periodic");
    end

    // read timeout
    rd_hang = 1;
    push_rd(1, 1);
    wait_drain("rd_hang");
    rd_hang = 0;
    push_rd(1, 0);
    wait_drain("rd_after_hang");
    check("err_rd_to_set", int'(err_rd_to), 1);
    pulse_clr();
    check("err_rd_to_clr", int'(err_rd_to), 0);

    // randomized reconfiguration requests during reads
    for (int k = 0; k < 7; k++) begin
      if (k == 0) m = 8'h0F;
      else if (k == 1) m = 8'h00;
      else m = 8'($urandom_range(255, 1));
      s = 4'($urandom);
      hang = -1;
      if (k == 0) hang = 2;
      else if (m != 0 && $urandom_range(3, 0) == 0) begin
        hang = $urandom_range(7, 0);
        while (!m[hang]) hang = (hang + 1) % 8;
      end
      for (int i = 0; i < 8; i++) stop_dly[i] = $urandom_range(60, 1);
      if (hang >= 0) stop_dly[hang] = 0;
      cfg_mask = m;
      cfg_select_in = s;
      pulse_req();
      push_cfg_seq(m, int'(s), hang < 0);
      push_rd(0, 0);
      wait_drain("cfg_seq");
      if (hang >= 0) begin
        check("err_cfg_to_set", int'(err_cfg_to), 1);
        check("err_dev", int'(err_dev), hang);
        check("cfg_valid_after_to", int'(cfg_valid), 0);
        stop_dly[hang] = 5;
        push_cfg_seq(m, int'(s), 1);
        push_rd(0, 0);
        wait_drain("cfg_retry");
        pulse_clr();
        check("err_cfg_to_clr", int'(err_cfg_to), 0);
      end
      check("cfg_valid_seq", int'(cfg_valid), 1);
      if (m != 0) check("cfg_sel_seq", int'(configure_select), int'(s));
    end

    // enable drop: current read finishes, then idle
    enable = 0;
    tick(300);
    check("dis_busy", int'(busy), 0);
    check("dis_state", int'(state_o), 0);
    check("dis_scan", int'(scan_count), m_count);
    push_rd(0, 0);
    enable = 1;
    wait_drain("reenable");

    // asynchronous reset during CFG_WAIT
    cfg_mask = 8'h81;
    cfg_select_in = 4'h5;
    stop_dly[0] = 40;
    pulse_req();
    sb.push_back('{1, 0, 5, 0, 1'b0});
    wait_drain("pre_reset");
    tick(5);
    rst = 0;
    #1;
    check("async_rst_outs", int'({start_configure, start_rd, cfg_valid,
                                  cfg_done, busy, state_o}), 0);
    check("async_rst_scan", int'(scan_count), 0);
    m_count = 0;
    stop_dly[0] = 10;
    stop_dly[7] = 10;
    push_cfg_seq(8'h81, 5, 1);
    push_rd(0, 0);
    tick(3);
    rst = 1;
    wait_drain("post_reset");
    push_rd(1, 0);
    wait_drain("post_reset_rd");

    tick(5);
    check("exclusion_onehot", viol, 0);
    check("sb_leftover", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim did not finish, got timeout want done");
    $fatal(1);
  end

endmodule
